// File: rtl/right_rotation.sv
// Barrel rotator: rotates din right by s through a log2(WIDTH)-level mux network.
// Define RIGHT_ROTATION_COMB_EN for a purely combinational stage; default is one registered stage.
module right_rotation #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic [SW-1:0]    s,
   input  logic             in_valid,
   output logic [WIDTH-1:0] dout,
   output logic             out_valid
);

   // Level k either passes its input through or rotates it right by 2^k.
   logic [SW:0][WIDTH-1:0] stage_s;

   assign stage_s[0] = din;

   for (genvar k = 0; k < SW; k++) begin : g_level
      localparam int AMT = 2 ** k;
      assign stage_s[k+1] = s[k] ? ((stage_s[k] >> AMT) | (stage_s[k] << (WIDTH - AMT)))
                                 : stage_s[k];
   end

`ifdef RIGHT_ROTATION_COMB_EN

   // Clock and reset stay on the port list so both builds share one footprint.
   logic unused_s;
   assign unused_s  = clk ^ rst;

   assign dout      = stage_s[SW];
   assign out_valid = in_valid;

`else

   // Output register: reset wins over a valid input, dout holds when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout      <= {WIDTH{1'b0}};
         out_valid <= 1'b0;
      end else if (in_valid) begin
         dout      <= stage_s[SW];
         out_valid <= 1'b1;
      end else begin
         dout      <= dout;
         out_valid <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_right_rotation.sv
// Self-checking bench for right_rotation (WIDTH=8); follows RIGHT_ROTATION_COMB_EN when defined.
module tb_right_rotation;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic [2:0] s;
   logic       in_valid;
   logic [7:0] dout;
   logic       out_valid;

   int tests = 0;
   int fails = 0;

   logic [7:0] m_dout;
   logic       m_valid;

   logic [7:0] sweep_exp [8] = '{8'b10000001, 8'b11000000, 8'b01100000, 8'b00110000,
                                 8'b00011000, 8'b00001100, 8'b00000110, 8'b00000011};

   always #5 clk = ~clk;

   right_rotation #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .s         (s),
      .in_valid  (in_valid),
      .dout      (dout),
      .out_valid (out_valid)
   );

   function automatic logic [7:0] rotr_ref(input logic [7:0] d, input int sh);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[(i + sh) % 8];
      return r;
   endfunction

   function automatic int popc(input logic [7:0] d);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(d[i]);
      return n;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] d, input logic [2:0] sh);
      rst = r; in_valid = v; din = d; s = sh;
      @(posedge clk);
      #1;
`ifdef RIGHT_ROTATION_COMB_EN
      m_dout  = rotr_ref(d, int'(sh));
      m_valid = v;
`else
      if (r) begin
         m_dout  = 8'h00;
         m_valid = 1'b0;
      end else if (v) begin
         m_dout  = rotr_ref(d, int'(sh));
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
`endif
      check("dout_model", dout, m_dout);
      check("out_valid_model", {7'd0, out_valid}, {7'd0, m_valid});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; din = 8'h00; s = 3'd0;
      m_dout = 8'h00; m_valid = 1'b0;

      // Reset held two edges with a valid all-ones input present.
      step(1'b1, 1'b1, 8'hFF, 3'd0);
      step(1'b1, 1'b1, 8'hFF, 3'd0);
`ifdef RIGHT_ROTATION_COMB_EN
      check("reset_passthru", dout, 8'hFF);
`else
      check("reset_dout", dout, 8'h00);
      check("reset_valid", {7'd0, out_valid}, 8'h00);
`endif
      step(1'b0, 1'b0, 8'hFF, 3'd0);
      step(1'b0, 1'b0, 8'hFF, 3'd0);
`ifndef RIGHT_ROTATION_COMB_EN
      check("post_reset_idle", dout, 8'h00);
`endif

      // Full amount sweep of 10000001.
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 8'b10000001, 3'(k));
         check("sweep", dout, sweep_exp[k]);
      end

      // Wrap-around amounts.
      step(1'b0, 1'b1, 8'b11111110, 3'd1);
      check("wrap_s1", dout, 8'b01111111);
      step(1'b0, 1'b1, 8'b11111110, 3'd7);
      check("wrap_s7", dout, 8'b11111101);

      // Hold when idle.
      step(1'b0, 1'b1, 8'hA5, 3'd4);
      check("nibble_swap", dout, 8'h5A);
      step(1'b0, 1'b0, 8'h00, 3'd0);
`ifndef RIGHT_ROTATION_COMB_EN
      check("hold", dout, 8'h5A);
`endif

      // Reset beats a simultaneous valid input.
      step(1'b1, 1'b1, 8'h81, 3'd1);
`ifndef RIGHT_ROTATION_COMB_EN
      check("reset_priority", dout, 8'h00);
`endif

      // Random traffic, mostly valid, with popcount preservation.
      for (int n = 0; n < 1000; n++) begin
         logic [7:0] d;
         logic [2:0] sh;
         logic       v;
         d  = 8'($urandom);
         sh = 3'($urandom_range(0, 7));
         v  = ($urandom_range(0, 7) != 0);
         step(1'b0, v, d, sh);
         if (v) check("popcount", 8'(popc(dout)), 8'(popc(d)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
